times_table_arbiter: RTL

- Shares one `times_tables` multiplier (3-bit a, b, 6-bit result, registered output, `enable` qualified) between two requesters.
- Each requester uses a valid/ready request handshake and receives a one-cycle response pulse carrying the product.
- A round-robin policy arbitrates between requesters.
- An FSM sequences the multiplier: issue, wait for its latency, capture the product, respond.

---
 rtl/tt_arb_pkg.sv | 15 +
 rtl/times_table_arbiter_if.sv | 37 +++
 rtl/rr_arb2.sv | 18 +
 rtl/times_table_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/tt_arb_pkg.sv
// Shared constants and FSM encoding for the times_table_arbiter slice.
package tt_arb_pkg;

  localparam int unsigned OP_W_DEF  = 3;
  localparam int unsigned RES_W_DEF = 2 * OP_W_DEF;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/times_table_arbiter_if.sv
// Request, response and multiplier-side signals of times_table_arbiter.
// master: requesters plus multiplier model; slave: the arbiter.
interface times_table_arbiter_if #(
  parameter int unsigned OP_W = tt_arb_pkg::OP_W_DEF
);
  localparam int unsigned RES_W = 2 * OP_W;

  logic             req0_valid;
  logic [OP_W-1:0]  req0_a;
  logic [OP_W-1:0]  req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [OP_W-1:0]  req1_a;
  logic [OP_W-1:0]  req1_b;
  logic             req1_ready;
  logic             resp0_valid;
  logic             resp1_valid;
  logic [RES_W-1:0] resp_result;
  logic             mul_enable;
  logic [OP_W-1:0]  mul_a;
  logic [OP_W-1:0]  mul_b;
  logic [RES_W-1:0] mul_result;
  logic             err;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_result,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_result,
    input  mul_enable, mul_a, mul_b, err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_result,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_result,
    output mul_enable, mul_a, mul_b, err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the requester other than last_grant wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/times_table_arbiter.sv
// Shares one registered times_tables multiplier between two valid/ready requesters.
// Optional result checker enabled by defining TT_ARB_CHECK_EN.
module times_table_arbiter
  import tt_arb_pkg::*;
#(
  parameter int unsigned OP_W        = OP_W_DEF,
  parameter int unsigned MUL_LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst,
  times_table_arbiter_if.slave bus
);

  localparam int unsigned      RES_W = 2 * OP_W;
  localparam logic [CNT_W-1:0] LAT   = CNT_W'(MUL_LATENCY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [OP_W-1:0]  mul_a_q, mul_b_q;
  logic [RES_W-1:0] resp_result_q;
  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             accept;
  logic             capture;

  rr_arb2 u_rr_arb2 (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign ready   = (state_q == StIdle) ? grant : 2'b00;
  assign accept  = |ready;
  assign capture = (state_q == StWait) && (cnt_q == LAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (capture) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req0_ready  = ready[0];
    bus.req1_ready  = ready[1];
    bus.mul_enable  = (state_q == StIssue);
    bus.resp0_valid = (state_q == StResp) && !owner_q;
    bus.resp1_valid = (state_q == StResp) && owner_q;
  end

  // Operands, owner and product are held until the next accept / capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      resp_result_q <= '0;
    end else begin
      if (accept) begin
        mul_a_q      <= grant[1] ? bus.req1_a : bus.req0_a;
        mul_b_q      <= grant[1] ? bus.req1_b : bus.req0_b;
        owner_q      <= grant[1];
        last_grant_q <= grant[1];
      end
      if (state_q == StIssue) begin
        cnt_q <= CNT_W'(1);
      end else if (capture) begin
        cnt_q         <= '0;
        resp_result_q <= bus.mul_result;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.resp_result = resp_result_q;

`ifdef TT_ARB_CHECK_EN
  logic             err_q;
  logic [RES_W-1:0] expect_prod;

  assign expect_prod = RES_W'(mul_a_q) * RES_W'(mul_b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (capture && (bus.mul_result != expect_prod)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
